// File: rtl/norm_ctrl.sv
// Leading-one normalization controller: loads an operand into the
// shift register, then shifts left until its MSB reads 1.
module norm_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_in,
  output logic             ld,
  output logic             shen,
  output logic [CNT_W-1:0] shamt,
  output logic             zero_flag,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SH_MAX = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] shamt_nxt;
  logic             zero_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shamt     <= '0;
      zero_flag <= 1'b0;
    end else begin
      state     <= state_nxt;
      shamt     <= shamt_nxt;
      zero_flag <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shamt_nxt = shamt;
    zero_nxt  = zero_flag;
    ld        = 1'b0;
    shen      = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        ld        = 1'b1;
        shamt_nxt = '0;
        zero_nxt  = (data_in == '0);
        state_nxt = (data_in == '0) ? DONE : SCAN;
      end
      SCAN: begin
        shen = ~msb_in;
        if (msb_in) begin
          state_nxt = DONE;
        end else if (shamt == SH_MAX) begin
          // final shift with the count held saturated
          state_nxt = DONE;
        end else begin
          shamt_nxt = shamt + 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_norm_ctrl.sv
// Self-checking bench for norm_ctrl with a behavioural shift register
// and a leading-zero reference model.
module tb_norm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        msb_in;
  logic        ld;
  logic        shen;
  logic [3:0]  shamt;
  logic        zero_flag;
  logic        busy;
  logic        done;

  logic [15:0] sr;

  int checks = 0;
  int failures = 0;

  norm_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .msb_in   (msb_in),
    .ld       (ld),
    .shen     (shen),
    .shamt    (shamt),
    .zero_flag(zero_flag),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ld) sr <= data_in;
    else if (shen) sr <= {sr[14:0], 1'b0};
  end
  assign msb_in = sr[15];

  typedef struct {
    logic [15:0] d;
    int          n_shen;
    int          done_cyc;
    int          shamt;
    int          zf;
    logic [15:0] reg_val;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // reference: computed from the leading-zero count of the operand
  function automatic vec_t model(input logic [15:0] d);
    vec_t v;
    int n;
    n = 0;
    while (n < 16 && d[15-n] == 1'b0) n++;
    v.d = d;
    if (d == 0) begin
      v.n_shen = 0; v.done_cyc = 2; v.shamt = 0; v.zf = 1; v.reg_val = 0;
    end else begin
      v.n_shen = n; v.done_cyc = n + 3; v.shamt = n; v.zf = 0;
      v.reg_val = d << n;
    end
    return v;
  endfunction

  // cycle 0 = IDLE cycle in which start is sampled
  task automatic run_op(input vec_t v, input string tag);
    int cyc, lds, shens, done_c, ovl;
    @(negedge clk);
    data_in = v.d;
    start = 1'b1;
    cyc = 0; lds = 0; shens = 0; done_c = -1; ovl = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (ld) lds++;
      if (shen) shens++;
      if (ld && shen) ovl = 1;
      if (cyc == 1) chk({tag, " ld_at_1"}, ld, 1);
      if (done) begin
        done_c = cyc;
        break;
      end
    end
    chk({tag, " done_cyc"}, done_c, v.done_cyc);
    chk({tag, " ld_cnt"}, lds, 1);
    chk({tag, " shen_cnt"}, shens, v.n_shen);
    chk({tag, " ld_shen_overlap"}, ovl, 0);
    chk({tag, " shamt"}, shamt, v.shamt);
    chk({tag, " zero_flag"}, zero_flag, v.zf);
    if (!v.zf) chk({tag, " reg"}, sr, v.reg_val);
    @(negedge clk);
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " shamt_hold"}, shamt, v.shamt);
  endtask

  initial begin
    vec_t tbl[4];
    vec_t v;
    int lds, cyc, done_c;

    tbl[0] = '{16'h8000, 0, 3, 0, 0, 16'h8000};
    tbl[1] = '{16'h0001, 15, 18, 15, 0, 16'h8000};
    tbl[2] = '{16'h00F0, 8, 11, 8, 0, 16'hF000};
    tbl[3] = '{16'h0000, 0, 2, 0, 1, 16'h0000};

    rst = 1'b0;
    start = 1'b0;
    data_in = '0;
    #12;
    chk("reset_outs", {ld, shen, busy, done, zero_flag, shamt}, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

    for (int k = 0; k < 20; k++) begin
      logic [15:0] d;
      d = 16'($urandom) >> $urandom_range(0, 16);
      v = model(d);
      run_op(v, $sformatf("rnd%0d_%04h", k, d));
    end

    // start held high across a whole operation
    @(negedge clk);
    data_in = 16'h0100;
    start = 1'b1;
    cyc = 0; lds = 0; done_c = -1;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ld && busy) lds++;
      if (done) begin
        done_c = cyc;
        break;
      end
    end
    chk("hold done_cyc", done_c, 10);
    chk("hold ld_cnt", lds, 1);
    chk("hold shamt", shamt, 7);
    @(negedge clk);
    chk("hold idle_after_done", busy, 0);
    @(negedge clk);
    chk("hold second_load", ld, 1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("hold second_done", done, 1);
    @(negedge clk);

    // async reset in the middle of a scan
    @(negedge clk);
    data_in = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (shamt != 4'd5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst mid_shamt", shamt, 5);
    chk("rst mid_shen", shen, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("rst async_outs", {ld, shen, busy, done, zero_flag, shamt}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst stays_idle", {ld, shen, busy, done, zero_flag, shamt}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/norm_ctrl.md
Name: norm_ctrl

Overview:
- Leading-one normalization controller that sits directly upstream of the operand shift register and drives that register's `ld` and `shen` controls.
- On `start` it loads an operand into the register, then shifts left until the register's `MSB_out` reads 1.
- It reports the number of shifts (`shamt`) and a zero-operand flag, for use by the downstream multiplier/exponent logic.

Parameters:
- `WIDTH`, 16, operand width; must match the shift register's width.
- `CNT_W`, 4, width of `shamt`; must satisfy 2^CNT_W >= WIDTH.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous reset, active-low.
- `start`  input  1  request to normalize `data_in`; sampled only in IDLE.
- `data_in`  input  WIDTH  operand; the same bus drives the shift register's `par_in`. Must be stable during the LOAD cycle.
- `msb_in`  input  1  the shift register's `MSB_out`.
- `ld`  output  1  parallel-load strobe to the shift register.
- `shen`  output  1  shift-enable to the shift register.
- `shamt`  output  CNT_W  leading-zero count (shifts performed).
- `zero_flag`  output  1  operand was all zeros.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle completion pulse.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - State goes to IDLE immediately.
  - `ld`=0, `shen`=0, `done`=0, `busy`=0, `shamt`=0, `zero_flag`=0.
  - Reset mid-operation aborts the operation; the shift register content is don't-care afterwards.
- States: IDLE, LOAD, SCAN, DONE; 2-bit state register.
- IDLE:
  - All strobes are 0.
  - `start`=1 at a rising edge moves the FSM to LOAD.
- LOAD (exactly one cycle):
  - `ld`=1, `shen`=0.
  - At the edge: `shamt`<=0 and `zero_flag`<=(`data_in`==0).
  - Next state is DONE if `data_in`==0, otherwise SCAN.
- SCAN:
  - `shen` = ~`msb_in` (Mealy, combinational); `ld`=0.
  - If `msb_in`=0: `shamt`<=`shamt`+1 at the edge and the FSM stays in SCAN.
  - If `msb_in`=1: go to DONE with no shift and no increment.
  - Safety: if `shamt`==WIDTH-1 and `msb_in`=0, assert `shen` for that final shift, increment to WIDTH-1 is not exceeded (stay saturated), then go to DONE. This case is unreachable for a nonzero operand.
- DONE:
  - `done`=1 for one cycle, then go to IDLE.
- `ld` and `shen` are never high in the same cycle.
- `busy` = (state != IDLE).
- `shamt` and `zero_flag` hold their values from DONE until the next LOAD.
- `start` is ignored while `busy`=1. It is honoured in the IDLE cycle that follows DONE.
- Latency, with cycle 0 = IDLE cycle in which `start` is sampled and n = leading-zero count of the operand:
  - Cycle 1: LOAD.
  - Cycles 2..n+2: SCAN, with `shen`=1 in the first n of these.
  - Cycle n+3: `done`.
  - Zero operand: `done` in cycle 2 with no SCAN.
- Arithmetic: `shamt` is unsigned and never wraps; the maximum value is WIDTH-1.

Test Plan:
- `data_in`=16'h8000, `start` pulse -> one `ld` cycle, zero `shen` cycles, `done` at cycle 3, `shamt`=0, `zero_flag`=0.
- `data_in`=16'h0001 -> 15 consecutive `shen` cycles, `done` at cycle 18, `shamt`=15, `zero_flag`=0, shift register holds 16'h8000.
- `data_in`=16'h00F0 -> 8 `shen` cycles, `shamt`=8, register holds 16'hF000, `done` at cycle 11.
- `data_in`=16'h0000 -> `ld` in cycle 1, no `shen`, `done` at cycle 2, `zero_flag`=1, `shamt`=0.
- `start` held high for the whole operation on 16'h0100 -> exactly one operation (`shamt`=7). A second LOAD begins in the cycle after the IDLE that follows `done`. No extra `ld` pulses occur while `busy`.
- `rst` pulled low during SCAN (16'h0001, after 5 shifts) -> `shen`, `busy` and `shamt` go to 0 asynchronously; after release with `start`=0 the FSM stays in IDLE with all outputs 0.
